// File: rtl/mult_ctrl_8x8_if.sv
// Operand/control bundle between the shift-add multiplier control unit and its environment.
// The 9-bit add/sub stage sits outside the block and closes the loop through add_s.
interface mult_ctrl_8x8_if #(parameter int N_BITS = 8);
    logic              Run;
    logic              ClearA_LoadB;
    logic [N_BITS-1:0] SW;
    logic [N_BITS:0]   add_a;
    logic [N_BITS:0]   add_b;
    logic              add_fn;
    logic [N_BITS:0]   add_s;
    logic [N_BITS-1:0] Aval;
    logic [N_BITS-1:0] Bval;
    logic              Xval;
    logic              busy;
    logic              done;

    modport slave (
        input  Run, ClearA_LoadB, SW, add_s,
        output add_a, add_b, add_fn, Aval, Bval, Xval, busy, done
    );

    modport master (
        output Run, ClearA_LoadB, SW, add_s,
        input  add_a, add_b, add_fn, Aval, Bval, Xval, busy, done
    );
endinterface

// File: rtl/mult_ctrl_8x8.sv
// Register unit + control FSM for an 8x8 signed shift-add multiplier; product lands in {A,B}.
// Latency: 16 busy cycles (ADD/SHIFT pairs) after the start edge; no backpressure, Run is a level request.
module mult_ctrl_8x8 #(
    parameter int N_BITS = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    mult_ctrl_8x8_if.slave  bus
);
    localparam int CW = $clog2(N_BITS);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              x_q, x_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              last_step;
    logic              start;

    assign last_step = (cnt_q == CW'(N_BITS - 1));
    assign start     = bus.Run && !run_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        run_d   = bus.Run;
        unique case (state_q)
            S_IDLE: begin
                // A start wins over a same-cycle load; B is kept as the multiplier.
                if (start) begin
                    x_d     = 1'b0;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ADD;
                end else if (bus.ClearA_LoadB) begin
                    x_d = 1'b0;
                    a_d = '0;
                    b_d = bus.SW;
                end
            end
            S_ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = bus.add_s;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {x_d, a_d, b_d} = {x_q, x_q, a_q, b_q[N_BITS-1:1]};
                cnt_d           = cnt_q + CW'(1);
                state_d         = last_step ? S_DONE : S_ADD;
            end
            S_DONE: begin
                if (!bus.Run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The multiplier MSB carries negative weight, so the final step subtracts S.
    assign bus.add_a  = {x_q, a_q};
    assign bus.add_b  = {bus.SW[N_BITS-1], bus.SW};
    assign bus.add_fn = last_step;
    assign bus.Aval   = a_q;
    assign bus.Bval   = b_q;
    assign bus.Xval   = x_q;
    assign bus.busy   = (state_q == S_ADD) || (state_q == S_SHIFT);
    assign bus.done   = (state_q == S_DONE);
endmodule

// File: tb/tb_mult_ctrl_8x8.sv
// Scoreboarded bench for mult_ctrl_8x8 with an arithmetic signed-product reference and an external adder model.
module tb_mult_ctrl_8x8;
    logic Clk;
    logic Reset;
    int   checks;
    int   failures;

    mult_ctrl_8x8_if #(.N_BITS(8)) bus ();

    mult_ctrl_8x8 #(.N_BITS(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Environment adder: a + (b ^ fn) + fn, wrapping at 9 bits.
    assign bus.add_s = bus.add_a + (bus.add_b ^ {9{bus.add_fn}}) + {8'd0, bus.add_fn};

    always #5 Clk = ~Clk;

    logic [16:0] exp_q[$];
    logic [7:0]  model_b;
    logic [16:0] last_exp;
    logic        done_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] ref_product(input logic [7:0] s, input logic [7:0] b);
        int p;
        p = int'($signed(s)) * int'($signed(b));
        return {p[15], p[15:0]};
    endfunction

    // Monitor: every rising done presents a product, compared against the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("sb_product", {15'd0, bus.Xval, bus.Aval, bus.Bval}, {15'd0, e});
                chk("sb_x_sign", {31'd0, bus.Xval}, {31'd0, bus.Aval[7]});
            end
        end
        done_prev = bus.done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic load_b(input logic [7:0] v);
        @(negedge Clk);
        bus.SW           = v;
        bus.ClearA_LoadB = 1'b1;
        @(negedge Clk);
        bus.ClearA_LoadB = 1'b0;
        model_b          = v;
    endtask

    // Start one multiply of S by the modelled B; pulse drops Run after the start edge.
    task automatic run_mult(input logic [7:0] s, input bit pulse, input bit clr_mid);
        int edges;
        int busyc;
        @(negedge Clk);
        bus.SW   = s;
        bus.Run  = 1'b1;
        last_exp = ref_product(s, model_b);
        exp_q.push_back(last_exp);
        model_b  = last_exp[7:0];
        edges    = 0;
        busyc    = 0;
        forever begin
            @(negedge Clk);
            edges++;
            if (bus.busy) busyc++;
            if (pulse && edges == 1) bus.Run = 1'b0;
            if (clr_mid && edges == 4) bus.ClearA_LoadB = 1'b1;
            if (clr_mid && edges == 5) bus.ClearA_LoadB = 1'b0;
            if (bus.done || edges > 40) break;
        end
        chk("done_latency", edges, 17);
        chk("busy_cycles", busyc, 16);
        idle(2);
    endtask

    initial begin
        Clk              = 1'b0;
        Reset            = 1'b1;
        checks           = 0;
        failures         = 0;
        done_prev        = 1'b0;
        model_b          = 8'd0;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.SW           = 8'd0;
        idle(3);
        chk("reset_regs", {23'd0, bus.Xval, bus.Aval, bus.Bval}, 32'd0);
        chk("reset_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        Reset = 1'b0;
        idle(1);

        // 7 x -3 = -21
        load_b(8'h07);
        chk("load_b", {23'd0, bus.Xval, bus.Aval, bus.Bval}, 32'h00007);
        run_mult(8'hFD, 1'b1, 1'b0);
        chk("t1_product", {15'd0, last_exp}, 32'h1FFEB);

        // -128 x -128 exercises the final subtract
        load_b(8'h80);
        run_mult(8'h80, 1'b1, 1'b0);
        chk("t2_product", {15'd0, last_exp}, 32'h04000);

        // -1 x 1, then back-to-back with the old low byte as multiplier
        load_b(8'hFF);
        run_mult(8'h01, 1'b1, 1'b0);
        chk("t3a_product", {15'd0, last_exp}, 32'h1FFFF);
        run_mult(8'h02, 1'b1, 1'b0);
        chk("t3b_product", {15'd0, last_exp}, 32'h1FFFE);

        // Run held high through DONE must not retrigger
        load_b(8'h35);
        run_mult(8'hC4, 1'b0, 1'b0);
        begin
            int hb;
            int hd;
            hb = 0;
            hd = 0;
            repeat (20) begin
                @(negedge Clk);
                if (bus.busy) hb++;
                if (!bus.done) hd++;
            end
            chk("hold_no_restart", hb, 0);
            chk("hold_done_stays", hd, 0);
            chk("hold_regs", {15'd0, bus.Xval, bus.Aval, bus.Bval}, {15'd0, last_exp});
        end
        bus.Run = 1'b0;
        @(negedge Clk);
        chk("drop_run_idle", {31'd0, bus.done}, 32'd0);
        run_mult(8'h13, 1'b1, 1'b0);

        // ClearA_LoadB pulsed while busy leaves B alone (product stays correct)
        load_b(8'h5A);
        run_mult(8'h27, 1'b1, 1'b1);

        // Reset at cycle 5 of a run aborts it
        load_b(8'h6B);
        @(negedge Clk);
        bus.SW  = 8'h3C;
        bus.Run = 1'b1;
        idle(1);
        bus.Run = 1'b0;
        idle(4);
        Reset = 1'b1;
        @(negedge Clk);
        chk("abort_regs", {23'd0, bus.Xval, bus.Aval, bus.Bval}, 32'd0);
        chk("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        Reset   = 1'b0;
        model_b = 8'd0;
        idle(2);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            run_mult(8'($urandom), 1'b1, 1'b0);
        end

        idle(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
